// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// alu_muldiv_iter : iterative RV32M multiply/divide unit, one bit per cycle.
// Option ALU_MULDIV_EARLY_OUT_EN : multiply exits once the multiplier is spent.
// Rev 1.0
// ============================================================================
module alu_muldiv_iter #(
   parameter int width_p          = 32,
   parameter int reg_addr_width_p = 5
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        v_i,
   output logic                        ready_o,
   input  logic [2:0]                  op_i,
   input  logic [width_p-1:0]          rs1_i,
   input  logic [width_p-1:0]          rs2_i,
   input  logic [reg_addr_width_p-1:0] rd_i,
   output logic                        v_o,
   output logic [width_p-1:0]          result_o,
   output logic [reg_addr_width_p-1:0] rd_o,
   input  logic                        yumi_i
);

   localparam int CNT_W = $clog2(width_p + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   state_e                        state_q;
   logic                          ready_q;
   logic                          v_q;
   logic [width_p-1:0]            result_q;
   logic [reg_addr_width_p-1:0]   rd_q;
   logic [2:0]                    op_q;
   logic                          neg_q;
   logic [CNT_W-1:0]              cnt_q;
   logic [2*width_p-1:0]          acc_q;
   logic [2*width_p-1:0]          mcand_q;
   // Multiplier while multiplying; dividend shifting out / quotient shifting in while dividing.
   logic [width_p-1:0]            mplier_q;
   logic [width_p-1:0]            divisor_q;
   logic [width_p-1:0]            prem_q;

   logic                          rs1_signed_d;
   logic                          rs2_signed_d;
   logic                          sign1_d;
   logic                          sign2_d;
   logic                          neg_d;
   logic [width_p-1:0]            mag1_d;
   logic [width_p-1:0]            mag2_d;

   always_comb begin
      rs1_signed_d = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01 || op_i[1:0] == 2'b10);
      rs2_signed_d = op_i[2] ? ~op_i[0] : (op_i[1:0] == 2'b01);
      sign1_d      = rs1_signed_d & rs1_i[width_p-1];
      sign2_d      = rs2_signed_d & rs2_i[width_p-1];
      mag1_d       = sign1_d ? -rs1_i : rs1_i;
      mag2_d       = sign2_d ? -rs2_i : rs2_i;
      // REM/REMU take the dividend sign; everything else the product/quotient sign.
      neg_d        = (op_i[2] & op_i[1]) ? sign1_d : (sign1_d ^ sign2_d);
   end

   logic [2*width_p-1:0]          acc_d;
   logic [width_p:0]              trial_d;
   logic [width_p:0]              diff_d;
   logic [width_p-1:0]            prem_d;
   logic [width_p-1:0]            quot_d;
   logic                          calc_last_d;

   always_comb begin
      acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      trial_d = {prem_q, mplier_q[width_p-1]};
      // Borrow out of the width_p+1 bit subtraction means the trial is below the divisor.
      diff_d  = trial_d - {1'b0, divisor_q};
      prem_d  = diff_d[width_p] ? trial_d[width_p-1:0] : diff_d[width_p-1:0];
      quot_d  = {mplier_q[width_p-2:0], ~diff_d[width_p]};
      calc_last_d = (cnt_q == CNT_W'(1));
`ifdef ALU_MULDIV_EARLY_OUT_EN
      if (!op_q[2] && (mplier_q[width_p-1:1] == '0)) begin
         calc_last_d = 1'b1;
      end
`endif
   end

   logic [2*width_p-1:0]          prod_d;
   logic [width_p-1:0]            quot_fix_d;
   logic [width_p-1:0]            rem_fix_d;
   logic [width_p-1:0]            result_d;

   always_comb begin
      prod_d     = neg_q ? -acc_q : acc_q;
      quot_fix_d = neg_q ? -mplier_q : mplier_q;
      rem_fix_d  = neg_q ? -prem_q : prem_q;
      case (op_q)
         3'b000:                 result_d = prod_d[width_p-1:0];
         3'b001, 3'b010, 3'b011: result_d = prod_d[2*width_p-1:width_p];
         3'b100, 3'b101:         result_d = quot_fix_d;
         default:                result_d = rem_fix_d;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         v_q       <= 1'b0;
         result_q  <= '0;
         rd_q      <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         divisor_q <= '0;
         prem_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               ready_q <= 1'b1;
               if (v_i && ready_q) begin
                  ready_q   <= 1'b0;
                  op_q      <= op_i;
                  rd_q      <= rd_i;
                  neg_q     <= neg_d;
                  cnt_q     <= CNT_W'(width_p);
                  acc_q     <= '0;
                  prem_q    <= '0;
                  mcand_q   <= {{width_p{1'b0}}, mag1_d};
                  mplier_q  <= op_i[2] ? mag1_d : mag2_d;
                  divisor_q <= mag2_d;
                  if (op_i[2] && (rs2_i == '0)) begin
                     result_q <= op_i[1] ? rs1_i : '1;
                     v_q      <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (op_q[2]) begin
                  prem_q   <= prem_d;
                  mplier_q <= quot_d;
               end else begin
                  acc_q    <= acc_d;
                  mcand_q  <= mcand_q << 1;
                  mplier_q <= mplier_q >> 1;
               end
               if (calc_last_d) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               result_q <= result_d;
               v_q      <= 1'b1;
               state_q  <= DONE;
            end
            DONE: begin
               if (yumi_i) begin
                  v_q     <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready_o  = ready_q;
   assign v_o      = v_q;
   assign result_o = result_q;
   assign rd_o     = rd_q;

   yumi_only_when_valid : assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_q);

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_iter.sv
`default_nettype none
// tb_alu_muldiv_iter: directed and randomized checks of alu_muldiv_iter against a
// transaction-level model (plain arithmetic for results, cycle counts for latency).
module tb_alu_muldiv_iter;

   localparam int W = 32;
   localparam int R = 5;

   logic          clk_i     = 1'b0;
   logic          reset_n_i = 1'b1;
   logic          v_i       = 1'b0;
   logic          yumi_i    = 1'b0;
   logic [2:0]    op_i      = '0;
   logic [W-1:0]  rs1_i     = '0;
   logic [W-1:0]  rs2_i     = '0;
   logic [R-1:0]  rd_i      = '0;
   logic          ready_o;
   logic          v_o;
   logic [W-1:0]  result_o;
   logic [R-1:0]  rd_o;

   int vectors     = 0;
   int miscompares = 0;

   alu_muldiv_iter #(.width_p(W), .reg_addr_width_p(R)) dut (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .v_i      (v_i),
      .ready_o  (ready_o),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .rd_i     (rd_i),
      .v_o      (v_o),
      .result_o (result_o),
      .rd_o     (rd_o),
      .yumi_i   (yumi_i)
   );

   always #5 clk_i = ~clk_i;

   // RV32M semantics straight from the ISA rules, using wide native arithmetic.
   function automatic logic [W-1:0] model_res(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [63:0] p;
      longint      sa, sb, ua, ub;
      int          q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      model_res = '0;
      case (op)
         3'b000: begin p = ua * ub; model_res = p[31:0];  end
         3'b001: begin p = sa * sb; model_res = p[63:32]; end
         3'b010: begin p = sa * ub; model_res = p[63:32]; end
         3'b011: begin p = ua * ub; model_res = p[63:32]; end
         3'b100: begin
            if (b == '0) model_res = '1;
            else if (a == 32'h8000_0000 && b == '1) model_res = a;
            else begin q = $signed(a) / $signed(b); model_res = q; end
         end
         3'b101: model_res = (b == '0) ? '1 : a / b;
         3'b110: begin
            if (b == '0) model_res = a;
            else if (a == 32'h8000_0000 && b == '1) model_res = '0;
            else begin q = $signed(a) % $signed(b); model_res = q; end
         end
         default: model_res = (b == '0) ? a : a % b;
      endcase
   endfunction

   // Rising edges after the accept edge until v_o is visible.
   function automatic int model_lat(input logic [2:0] op, input logic [W-1:0] b);
      if (op[2]) return (b == '0) ? 0 : W + 1;
`ifdef ALU_MULDIV_EARLY_OUT_EN
      begin
         logic [W-1:0] m;
         int           bl;
         m  = (op == 3'b001 && b[W-1]) ? -b : b;
         bl = 0;
         for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
         return 1 + ((bl < 1) ? 1 : bl);
      end
`else
      return W + 1;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model of the unit's externally visible state.
   logic          m_ready = 1'b0;
   logic          m_valid = 1'b0;
   logic          m_busy  = 1'b0;
   int            m_cnt   = 0;
   logic [W-1:0]  m_res   = '0;
   logic [R-1:0]  m_rd    = '0;

   always @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         m_ready <= 1'b0;
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
         m_cnt   <= 0;
      end else if (m_valid) begin
         if (yumi_i) begin
            m_valid <= 1'b0;
            m_ready <= 1'b1;
         end
      end else if (m_busy) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
         end
      end else if (m_ready && v_i) begin
         m_ready <= 1'b0;
         m_res   <= model_res(op_i, rs1_i, rs2_i);
         m_rd    <= rd_i;
         if (model_lat(op_i, rs2_i) == 0) begin
            m_valid <= 1'b1;
         end else begin
            m_busy <= 1'b1;
            m_cnt  <= model_lat(op_i, rs2_i);
         end
      end else begin
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk_i) begin
      chk("ready_o", 32'(ready_o), 32'(m_ready));
      chk("v_o", 32'(v_o), 32'(m_valid));
      if (m_valid) begin
         chk("result_o", result_o, m_res);
         chk("rd_o", 32'(rd_o), 32'(m_rd));
      end
   end

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'd1;
         2:       return '1;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 255));
         5:       return -32'($urandom_range(1, 255));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [R-1:0] rd);
      int g;
      g = 0;
      while (!ready_o && g < 100) begin
         @(negedge clk_i);
         g++;
      end
      chk("ready before issue", 32'(ready_o), 32'd1);
      v_i   = 1'b1;
      op_i  = op;
      rs1_i = a;
      rs2_i = b;
      rd_i  = rd;
      @(negedge clk_i);
      v_i   = 1'b0;
      op_i  = 3'($urandom);
      rs1_i = 32'($urandom);
      rs2_i = 32'($urandom);
      rd_i  = R'($urandom);
   endtask

   // cyc = 1 at the first sample after the accept edge.
   task automatic wait_result(output int cyc);
      cyc = 1;
      while (!v_o && cyc < 100) begin
         v_i   = 1'($urandom);
         rs1_i = 32'($urandom);
         @(negedge clk_i);
         cyc++;
      end
      v_i = 1'b0;
   endtask

   task automatic take(input int hold);
      repeat (hold) begin
         v_i   = 1'($urandom);
         rs2_i = 32'($urandom);
         @(negedge clk_i);
      end
      v_i    = 1'b0;
      yumi_i = 1'b1;
      @(negedge clk_i);
      yumi_i = 1'b0;
   endtask

   task automatic directed(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp, input int exp_cyc);
      int cyc;
      issue(op, a, b, 5'd5);
      wait_result(cyc);
      chk({nm, " latency"}, 32'(cyc), 32'(exp_cyc));
      if (v_o) begin
         chk(nm, result_o, exp);
         chk({nm, " rd"}, 32'(rd_o), 32'd5);
         take(0);
      end
   endtask

`ifdef ALU_MULDIV_EARLY_OUT_EN
   localparam int SMALL_MUL_CYC = 4;
`else
   localparam int SMALL_MUL_CYC = 34;
`endif

   initial begin
      int cyc;
      #1 reset_n_i = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         chk("reset v_o", 32'(v_o), 32'd0);
         chk("reset result_o", result_o, 32'd0);
         chk("reset rd_o", 32'(rd_o), 32'd0);
         chk("reset ready_o", 32'(ready_o), 32'd0);
      end
      reset_n_i = 1'b1;
      @(negedge clk_i);
      chk("ready after reset", 32'(ready_o), 32'd1);

      directed("MUL",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      directed("MULHSU", 3'b010, 32'd7,        32'hFFFF_FFFD, 32'h0000_0006, 34);
      directed("MULH",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      directed("MULHU",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      directed("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
      directed("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
      directed("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 34);
      directed("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 34);
      directed("DIVU /0", 3'b101, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 1);
      directed("REMU /0", 3'b111, 32'h0000_1234, 32'd0,        32'h0000_1234, 1);
      directed("DIV -5/0", 3'b100, 32'hFFFF_FFFB, 32'd0,       32'hFFFF_FFFF, 1);
      directed("MUL x3", 3'b000, 32'd5,        32'd3,         32'd15,         SMALL_MUL_CYC);

      // Backpressure: result must hold while yumi stays low and new requests are refused.
      issue(3'b000, 32'h0000_1234, 32'h0000_0010, 5'd9);
      wait_result(cyc);
      chk("bp valid", 32'(v_o), 32'd1);
      repeat (5) begin
         v_i   = 1'b1;
         op_i  = 3'b101;
         rs1_i = 32'($urandom);
         rs2_i = 32'($urandom);
         @(negedge clk_i);
         chk("bp result", result_o, 32'h0001_2340);
         chk("bp rd", 32'(rd_o), 32'd9);
         chk("bp ready", 32'(ready_o), 32'd0);
      end
      v_i    = 1'b0;
      yumi_i = 1'b1;
      @(negedge clk_i);
      yumi_i = 1'b0;
      chk("ready after yumi", 32'(ready_o), 32'd1);
      directed("DIVU b2b", 3'b101, 32'd100, 32'd7, 32'd14, 34);

      // Abort a divide part-way through, then prove the unit recovers.
      issue(3'b100, 32'd1000, 32'd7, 5'd3);
      repeat (9) @(negedge clk_i);
      @(posedge clk_i);
      #2 reset_n_i = 1'b0;
      #1;
      chk("abort v_o", 32'(v_o), 32'd0);
      chk("abort ready_o", 32'(ready_o), 32'd0);
      repeat (2) @(negedge clk_i);
      reset_n_i = 1'b1;
      @(negedge clk_i);
      chk("abort no result", 32'(v_o), 32'd0);
      directed("DIV after reset", 3'b100, 32'd1000, 32'd7, 32'd142, 34);

      for (int n = 0; n < 200; n++) begin
         issue(3'($urandom), rnd_operand(), rnd_operand(), R'($urandom));
         wait_result(cyc);
         chk("random completes", 32'(v_o), 32'd1);
         if (v_o) take($urandom_range(0, 3));
      end

      repeat (3) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, expected summary before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
